// File: rtl/mem_lsu_if.sv
// ---------------------------------------------------------------------------
// mem_lsu_if : data-memory bus between the load/store unit and data memory.
//
// Protocol: req/gnt handshake for the address phase, then a separate
// rvalid/rdata response phase for reads.
//
// Signals
//   dmem_req    : bus request (LSU -> memory)
//   dmem_we     : 1 = write, 0 = read (LSU -> memory)
//   dmem_addr   : word-aligned byte address, bits [1:0] = 0 (LSU -> memory)
//   dmem_wstrb  : byte enables (LSU -> memory)
//   dmem_wdata  : lane-replicated store data (LSU -> memory)
//   dmem_gnt    : request accepted this cycle (memory -> LSU)
//   dmem_rvalid : read data valid (memory -> LSU)
//   dmem_rdata  : read data (memory -> LSU)
//
// Modports
//   master : the load/store unit side
//   slave  : the data-memory side
// ---------------------------------------------------------------------------
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_wstrb;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wstrb,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wstrb,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu : load/store unit for the MEM stage of the RV32I pipeline.
//
// Takes one memory operation from EX/MEM, runs it on the data-memory bus
// (req/gnt, then rvalid for loads), and stalls the pipeline while the
// transaction is outstanding. Load results are lane-aligned and sign- or
// zero-extended into mem_load_data.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   mem_valid       : EX/MEM holds a valid instruction
//   mem_is_load     : instruction is a load
//   mem_is_store    : instruction is a store
//   mem_funct3      : RV32I size/sign field
//   mem_addr        : effective byte address
//   mem_store_data  : rs2 value
//   lsu_stall       : freeze PC/IF/ID/EX/MEM, bubble into MEM/WB
//   mem_load_data   : formatted load result (held until the next load)
//   mem_load_done   : one-cycle pulse when a load result is valid
//   mem_fault       : misaligned access or illegal funct3 (combinational)
//   dmem            : data-memory bus, master side
// ---------------------------------------------------------------------------
module mem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_is_load,
  input  logic              mem_is_store,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_store_data,
  output logic              lsu_stall,
  output logic [31:0]       mem_load_data,
  output logic              mem_load_done,
  output logic              mem_fault,
  mem_lsu_if.master         dmem
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic              we_q,        we_d;
  logic [2:0]        funct3_q,    funct3_d;
  logic [1:0]        lane_q,      lane_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [3:0]        wstrb_q,     wstrb_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [31:0]       load_data_q, load_data_d;

  logic mem_op_s;
  logic legal_s;

  // Size/alignment legality: loads allow 000/001/010/100/101, stores 000/001/010.
  function automatic logic access_legal(input logic is_load, input logic [2:0] f3,
                                        input logic [1:0] lane);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~lane[0];
      3'b010:  ok = (lane == 2'b00);
      3'b100:  ok = is_load;
      3'b101:  ok = is_load & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] res;
    byte_sh = rdata >> {lane, 3'b000};
    half_sh = rdata >> {lane[1], 4'b0000};
    case (f3)
      3'b000:  res = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  res = {24'h00_0000, byte_sh[7:0]};
      3'b001:  res = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  res = {16'h0000, half_sh[15:0]};
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Byte enables from access size; halfword lane is addr[1] only.
  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      2'b00:   strb = 4'b0001 << lane;
      2'b01:   strb = 4'b0011 << {lane[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Replicate the store operand across all lanes so memory can use wstrb alone.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  assign mem_op_s = mem_valid & (mem_is_load | mem_is_store);
  assign legal_s  = access_legal(mem_is_load, mem_funct3, mem_addr[1:0]);

  // Next-state, capture and stall/fault decode.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    load_data_d = load_data_q;
    lsu_stall   = 1'b0;
    mem_fault   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          if (legal_s) begin
            // Load takes priority if both op flags are set.
            we_d      = ~mem_is_load;
            funct3_d  = mem_funct3;
            lane_d    = mem_addr[1:0];
            addr_d    = {mem_addr[ADDR_W-1:2], 2'b00};
            wstrb_d   = store_strb(mem_funct3[1:0], mem_addr[1:0]);
            wdata_d   = mem_is_load ? 32'h0000_0000
                                    : store_data(mem_funct3[1:0], mem_store_data);
            lsu_stall = 1'b1;
            state_d   = S_REQ;
          end else begin
            mem_fault = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        lsu_stall = 1'b1;
        if (dmem.dmem_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT_R;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT_R: begin
        lsu_stall = 1'b1;
        if (dmem.dmem_rvalid) begin
          load_data_d = format_load(funct3_q, lane_q, dmem.dmem_rdata);
          state_d     = S_DONE;
        end else begin
          state_d = S_WAIT_R;
        end
      end
      S_DONE: begin
        // The completed instruction is still on the inputs; never re-accept it here.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      lane_q      <= 2'b00;
      addr_q      <= '0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      load_data_q <= load_data_d;
    end
  end

  // Bus outputs come straight from registers, so they are stable through REQ
  // and drop asynchronously with rst_n.
  assign dmem.dmem_req   = (state_q == S_REQ);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign dmem.dmem_wdata = wdata_q;
  assign mem_load_data   = load_data_q;
  assign mem_load_done   = (state_q == S_DONE) & ~we_q;

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps
module tb_mem_lsu;
  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_is_load, mem_is_store;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_store_data;
  logic        lsu_stall, mem_load_done, mem_fault;
  logic [31:0] mem_load_data;

  mem_lsu_if #(.ADDR_W(ADDR_W)) dmem ();

  mem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
    .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
    .lsu_stall(lsu_stall), .mem_load_data(mem_load_data),
    .mem_load_done(mem_load_done), .mem_fault(mem_fault),
    .dmem(dmem)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t         op_q[$];        // accepted ops waiting for their bus grant
  logic [31:0] exp_load_q[$];  // expected mem_load_data per completing load
  int n_checks = 0, n_fail = 0;
  int gnt_delay = 0, rv_delay = 1, rv_countdown = 0, req_wait = 0;
  int gnt_count = 0, legal_issued = 0;
  logic [31:0] rd_pending = 32'h0, model_last = 32'h0, fixed_rdata = 32'h0;
  bit          fixed_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---- reference model -------------------------------------------------
  function automatic bit model_legal(input bit ld, input bit [2:0] f3, input logic [31:0] addr);
    int size;
    if (ld) begin
      if (f3 == 0 || f3 == 4) size = 1;
      else if (f3 == 1 || f3 == 5) size = 2;
      else if (f3 == 2) size = 4;
      else return 1'b0;
    end else begin
      if (f3 == 0) size = 1;
      else if (f3 == 1) size = 2;
      else if (f3 == 2) size = 4;
      else return 1'b0;
    end
    return (addr % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned lane, b, h;
    lane = addr % 4;
    b = (rdata >> (8 * lane)) % 256;
    h = (rdata >> (16 * (lane / 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      3'd5:    return 32'(h);
      default: return rdata;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    case (f3)
      3'd0:    return 4'(1 << (addr % 4));
      3'd1:    return 4'(3 << (addr % 4));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d % 256) * 32'h0101_0101;
      3'd1:    return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---- memory responder: grants after gnt_delay, answers after rv_delay --
  initial begin
    op_t cur;
    dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = $urandom;
      if (rv_countdown > 0) begin
        rv_countdown--;
        if (rv_countdown == 0) begin
          dmem.dmem_rvalid = 1'b1;
          dmem.dmem_rdata  = rd_pending;
        end
      end else if (dmem.dmem_req === 1'b1) begin
        check("req_expected", 32'(op_q.size() != 0), 32'd1);
        if (op_q.size() != 0) begin
          cur = op_q[0];
          check("dmem_addr", dmem.dmem_addr, cur.addr & 32'hFFFF_FFFC);
          check("dmem_we", 32'(dmem.dmem_we), 32'(!cur.is_load));
          if (!cur.is_load) begin
            check("dmem_wstrb", 32'(dmem.dmem_wstrb), 32'(model_strb(cur.f3, cur.addr)));
            check("dmem_wdata", dmem.dmem_wdata, model_wdata(cur.f3, cur.data));
          end
        end
        if (req_wait < gnt_delay) begin
          req_wait++;
        end else begin
          dmem.dmem_gnt = 1'b1;
          gnt_count++;
          req_wait = 0;
          if (op_q.size() != 0) begin
            cur = op_q.pop_front();
            if (cur.is_load) begin
              rd_pending = fixed_en ? fixed_rdata : $urandom;
              model_last = model_load(cur.f3, cur.addr, rd_pending);
              exp_load_q.push_back(model_last);
              rv_countdown = rv_delay;
            end
          end
        end
      end
    end
  end

  // ---- load-result monitor --------------------------------------------
  initial begin
    forever begin
      @(negedge clk); #1;
      if (mem_load_done === 1'b1) begin
        check("load_done_expected", 32'(exp_load_q.size() != 0), 32'd1);
        if (exp_load_q.size() != 0) check("load_data", mem_load_data, exp_load_q.pop_front());
      end
    end
  end

  // ---- driver ----------------------------------------------------------
  task automatic issue(input bit valid, input bit ld, input bit st, input bit [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int gd, input int rd);
    bit memop, legal;
    int exp_stall, stalls;
    op_t op;
    @(negedge clk);
    mem_valid = valid; mem_is_load = ld; mem_is_store = st;
    mem_funct3 = f3; mem_addr = addr; mem_store_data = data;
    gnt_delay = gd; rv_delay = rd;
    memop = valid && (ld || st);
    legal = model_legal(ld, f3, addr);
    exp_stall = 0;
    if (memop && legal) begin
      op.is_load = ld; op.f3 = f3; op.addr = addr; op.data = data;
      op_q.push_back(op);
      legal_issued++;
      exp_stall = ld ? 2 + gd + rd : 2 + gd;
    end
    #1;
    check("fault", 32'(mem_fault), 32'(memop && !legal));
    if (memop && !legal) check("fault_keeps_load_data", mem_load_data, model_last);
    stalls = 0;
    while (lsu_stall === 1'b1 && stalls < 64) begin
      stalls++;
      @(negedge clk); #1;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(lsu_stall), 32'd0);
    check({tag, "_load_data"}, mem_load_data, 32'd0);
    check({tag, "_load_done"}, 32'(mem_load_done), 32'd0);
    check({tag, "_fault"}, 32'(mem_fault), 32'd0);
    check({tag, "_req"}, 32'(dmem.dmem_req), 32'd0);
    check({tag, "_we"}, 32'(dmem.dmem_we), 32'd0);
    check({tag, "_addr"}, dmem.dmem_addr, 32'd0);
    check({tag, "_wstrb"}, 32'(dmem.dmem_wstrb), 32'd0);
    check({tag, "_wdata"}, dmem.dmem_wdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, waited, kind, gd, rd;
    logic [31:0] a, d;
    logic [2:0] f3;
    rst_n = 1'b0;
    mem_valid = 1'b0; mem_is_load = 1'b0; mem_is_store = 1'b0;
    mem_funct3 = 3'd0; mem_addr = 32'h0; mem_store_data = 32'h0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    // LW 0x100, immediate grant, rvalid next cycle
    fixed_en = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    issue(1, 1, 0, 3'd2, 32'h100, 32'h0, 0, 1);
    check("lw_const", mem_load_data, 32'hDEAD_BEEF);

    // sign/zero extension on fixed read data
    fixed_rdata = 32'h8011_2233;
    issue(1, 1, 0, 3'd0, 32'h103, 32'h0, 0, 1);
    check("lb_const", mem_load_data, 32'hFFFF_FF80);
    issue(1, 1, 0, 3'd4, 32'h103, 32'h0, 0, 1);
    check("lbu_const", mem_load_data, 32'h0000_0080);
    issue(1, 1, 0, 3'd5, 32'h102, 32'h0, 1, 2);
    check("lhu_const", mem_load_data, 32'h0000_8011);
    fixed_en = 1'b0;

    // SB 0x201 with grant delayed three cycles
    issue(1, 0, 1, 3'd0, 32'h201, 32'h0000_00A5, 3, 1);

    // misaligned LW: fault, no request, no stall
    issue(1, 1, 0, 3'd2, 32'h102, 32'h0, 0, 1);

    // back-to-back LW then SW with mem_valid continuous
    base = gnt_count;
    issue(1, 1, 0, 3'd2, 32'h400, 32'h0, 0, 1);
    issue(1, 0, 1, 3'd2, 32'h404, 32'h1234_5678, 0, 1);
    @(negedge clk); mem_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_two_requests", 32'(gnt_count - base), 32'd2);

    // randomized mix of loads, stores, illegal and non-memory ops
    for (int i = 0; i < 120; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom; d = $urandom; f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 3);
      case (kind)
        0:       issue(1, 0, 0, f3, a, d, gd, rd);
        1:       issue(0, 1, 0, f3, a, d, gd, rd);
        2, 3, 4, 5: issue(1, 1, 0, f3, a, d, gd, rd);
        default: issue(1, 0, 1, f3, a, d, gd, rd);
      endcase
    end

    // reset asserted in WAIT_R with rvalid still to come
    @(negedge clk);
    mem_valid = 1'b1; mem_is_load = 1'b1; mem_is_store = 1'b0;
    mem_funct3 = 3'd2; mem_addr = 32'h300;
    gnt_delay = 0; rv_delay = 3;
    op_q.push_back(op_t'{1'b1, 3'd2, 32'h300, 32'h0});
    legal_issued++;
    base = gnt_count; waited = 0;
    while (gnt_count == base && waited < 20) begin
      @(negedge clk); #1; waited++;
    end
    check("rst_test_gnt_seen", 32'(gnt_count), 32'(base + 1));
    @(negedge clk); #2;
    rst_n = 1'b0; mem_valid = 1'b0; mem_is_load = 1'b0;
    #1 check_all_zero("rst_mid");
    exp_load_q.delete();
    model_last = 32'h0;
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      check("late_rvalid_no_done", 32'(mem_load_done), 32'd0);
    end
    check("late_rvalid_data", mem_load_data, 32'd0);

    // recovery after reset
    issue(1, 1, 0, 3'd1, 32'h502, 32'h0, 0, 1);
    @(negedge clk); mem_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("gnt_count", 32'(gnt_count), 32'(legal_issued));
    check("op_q_empty", 32'(op_q.size()), 32'd0);
    check("exp_load_q_empty", 32'(exp_load_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
